noc_op_node: RTL

NOC_OP_NODE -- requirements
Module: noc_op_node

---
 rtl/noc_op_node.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/noc_op_node.sv
// noc_op_node: network-on-chip operator node.
//
// Gathers two operands from the network (or from local ports) and applies one
// fixed binary operation. The result goes back out as a single-flit packet.
// Each operand slot arriving from the network has its own FIFO. A result is
// issued only when every network-sourced slot holds an operand and a
// downstream credit is available.
//
// Flit layout, MSB first: {valid, tail, dest[DEST_W], vc, data[DATA_W]}.
//
// Ports:
//   CLK        in   1        single clock
//   RST        in   1        asynchronous active-high reset
//   flit_in    in   FLIT_W   receive port; vc selects slot (0 = A, 1 = B)
//   local_a    in   DATA_W   local operand A (used when LOCAL_A = 1)
//   local_b    in   DATA_W   local operand B (used when LOCAL_B = 1)
//   flit_out   out  FLIT_W   result flit, all zeros when idle
//   credit_in  in   2        {valid, vc}; a valid credit returns one slot
//   credit_out out  2        {vc1, vc0}; one-cycle pulse per operand FIFO pop
//   ops_done   out  16       wrapping count of issued results
//   err        out  3        sticky {credit_overflow, misroute, fifo_overflow}
module noc_op_node #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEST_W      = 4,
  parameter int unsigned NODE_ID     = 0,
  parameter int unsigned DEST_ID     = 0,
  parameter int unsigned OP_MODE     = 0,
  parameter int unsigned LOCAL_A     = 0,
  parameter int unsigned LOCAL_B     = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned NUM_CREDITS = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATA_W+DEST_W+2:0]   flit_in,
  input  logic [DATA_W-1:0]          local_a,
  input  logic [DATA_W-1:0]          local_b,
  output logic [DATA_W+DEST_W+2:0]   flit_out,
  input  logic [1:0]                 credit_in,
  output logic [1:0]                 credit_out,
  output logic [15:0]                ops_done,
  output logic [2:0]                 err
);

  localparam int unsigned FLIT_W = DATA_W + DEST_W + 3;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = $clog2(NUM_CREDITS + 1);
  localparam bit          NET_A  = (LOCAL_A == 0);
  localparam bit          NET_B  = (LOCAL_B == 0);

  // ---------------------------------------------------------------------------
  // Receive-side decode
  // ---------------------------------------------------------------------------
  logic              in_valid;
  logic              in_vc;
  logic [DEST_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic              dest_ok;
  logic              slot_net;

  assign in_valid = flit_in[FLIT_W-1];
  assign in_dest  = flit_in[DATA_W+1 +: DEST_W];
  assign in_vc    = flit_in[DATA_W];
  assign in_data  = flit_in[DATA_W-1:0];
  assign dest_ok  = (in_dest == DEST_W'(NODE_ID));
  assign slot_net = in_vc ? NET_B : NET_A;

  // The tail bit and the credit vc carry no meaning for a single-flit node.
  logic [1:0] unused_bits;
  assign unused_bits = {flit_in[FLIT_W-2], credit_in[0]};

  // ---------------------------------------------------------------------------
  // Operand FIFOs, index 0 = slot A, index 1 = slot B
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q    [2][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q [2];
  logic [AW-1:0]     rd_ptr_q [2];
  logic [AW:0]       cnt_q    [2];

  logic [1:0] fifo_empty;
  logic [1:0] fifo_full;
  logic [1:0] push;
  logic [1:0] pop;
  logic       fire;

  logic [CW-1:0] credit_q, credit_d;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      fifo_empty[s] = (cnt_q[s] == '0);
      fifo_full[s]  = (cnt_q[s] == (AW+1)'(FIFO_DEPTH));
    end
  end

  // Fire looks only at registered state, so a flit pushed at edge N is
  // consumed at edge N+1 at the earliest.
  assign fire = (!NET_A || !fifo_empty[0]) &&
                (!NET_B || !fifo_empty[1]) &&
                (credit_q != '0);

  assign pop[0] = fire && NET_A;
  assign pop[1] = fire && NET_B;

  // A full FIFO still accepts a flit when it is being popped at the same edge.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      push[s] = in_valid && dest_ok && slot_net && (in_vc == s[0]) &&
                (!fifo_full[s] || pop[s]);
    end
  end

  logic misroute;
  logic fifo_ovf;

  // A flit aimed at a locally-sourced slot counts as misrouted.
  assign misroute = in_valid && (!dest_ok || !slot_net);
  assign fifo_ovf = in_valid && dest_ok && slot_net &&
                    fifo_full[in_vc] && !pop[in_vc];

  // Storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge CLK) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_q[s][wr_ptr_q[s]] <= in_data;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (push[s]) begin
          wr_ptr_q[s] <= wr_ptr_q[s] + 1'b1;
        end
        if (pop[s]) begin
          rd_ptr_q[s] <= rd_ptr_q[s] + 1'b1;
        end
        unique case ({push[s], pop[s]})
          2'b10:   cnt_q[s] <= cnt_q[s] + 1'b1;
          2'b01:   cnt_q[s] <= cnt_q[s] - 1'b1;
          default: cnt_q[s] <= cnt_q[s];
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operation
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] result;

  assign op_a = NET_A ? mem_q[0][rd_ptr_q[0]] : local_a;
  assign op_b = NET_B ? mem_q[1][rd_ptr_q[1]] : local_b;

  // Every mode keeps only the low DATA_W bits (add wraps, mul truncates).
  always_comb begin
    result = '0;
    case (OP_MODE)
      0:       result = op_a + op_b;
      1:       result = op_a * op_b;
      2:       result = op_a & op_b;
      3:       result = op_a | op_b;
      4:       result = op_a ^ op_b;
      default: result = op_a + op_b;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Credits
  // ---------------------------------------------------------------------------
  logic credit_ret;
  logic credit_ovf;

  assign credit_ret = credit_in[1];

  always_comb begin
    credit_d   = credit_q;
    credit_ovf = 1'b0;
    unique case ({fire, credit_ret})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_q == CW'(NUM_CREDITS)) begin
          credit_ovf = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic [FLIT_W-1:0] flit_out_q, flit_out_d;
  logic [1:0]        credit_out_q;
  logic [15:0]       ops_done_q;
  logic [2:0]        err_q;

  always_comb begin
    flit_out_d = '0;
    if (fire) begin
      flit_out_d = {1'b1, 1'b1, DEST_W'(DEST_ID), 1'b0, result};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credit_q     <= CW'(NUM_CREDITS);
      flit_out_q   <= '0;
      credit_out_q <= '0;
      ops_done_q   <= '0;
      err_q        <= '0;
    end else begin
      credit_q     <= credit_d;
      flit_out_q   <= flit_out_d;
      credit_out_q <= {pop[1], pop[0]};
      ops_done_q   <= ops_done_q + {15'd0, fire};
      err_q        <= err_q | {credit_ovf, misroute, fifo_ovf};
    end
  end

  assign flit_out   = flit_out_q;
  assign credit_out = credit_out_q;
  assign ops_done   = ops_done_q;
  assign err        = err_q;

endmodule
